// File: rtl/vec_mul_simd_pipe_if.sv
// Handshake/data bundle for vec_mul_simd_pipe.
//   master: operation producer + result consumer (drives request side and out_ready)
//   slave : the multiplier pipeline
// Signals:
//   in_valid/in_ready        input handshake
//   operand_a/operand_b      packed lane operands, lane 0 at bit 0
//   opcode                   00 MUL, 01 MULH, 10 MULHU, 11 MULHSU
//   precision                lane width 00 8b, 01 16b, 10 32b, 11 64b
//   tag_in/tag_out           sideband carried with each operation
//   out_valid/out_ready      result handshake
//   mul_out                  packed lane results
interface vec_mul_simd_pipe_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [XLEN-1:0]  operand_a;
   logic [XLEN-1:0]  operand_b;
   logic [1:0]       opcode;
   logic [1:0]       precision;
   logic [TAG_W-1:0] tag_in;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  mul_out;
   logic [TAG_W-1:0] tag_out;

   modport master (
      output in_valid, operand_a, operand_b, opcode, precision, tag_in, out_ready,
      input  in_ready, out_valid, mul_out, tag_out
   );

   modport slave (
      input  in_valid, operand_a, operand_b, opcode, precision, tag_in, out_ready,
      output in_ready, out_valid, mul_out, tag_out
   );
endinterface

// File: rtl/vec_mul_simd_pipe.sv
// Pipelined SIMD integer multiplier (RISC-V M high/low semantics per lane).
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset; clears all stage valids and outputs
//   bus  vec_mul_simd_pipe_if.slave: valid/ready in, valid/ready out, operands,
//        opcode, precision, tag
// Parameters: XLEN (32|64), STAGES (1..4), TAG_W.
// Structure: with STAGES>1 the first stage registers operands and controls,
// the lane multiply sits between stage 1 and stage 2, and the remaining
// stages carry the result. With STAGES=1 the multiply feeds the output
// register directly. One global stall (advance) freezes every stage.
module vec_mul_simd_pipe #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned STAGES = 3,
   parameter int unsigned TAG_W  = 4
) (
   input  logic               clk,
   input  logic               rst,
   vec_mul_simd_pipe_if.slave bus
);

   typedef enum logic [1:0] {
      OP_MUL    = 2'b00,
      OP_MULH   = 2'b01,
      OP_MULHU  = 2'b10,
      OP_MULHSU = 2'b11
   } op_e;

   localparam int unsigned RDEPTH = (STAGES > 1) ? STAGES - 1 : 1;

   logic             advance;
   logic             src_valid;
   logic [XLEN-1:0]  src_a;
   logic [XLEN-1:0]  src_b;
   logic [1:0]       src_op;
   logic [1:0]       src_prec;
   logic [TAG_W-1:0] src_tag;

   assign advance      = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = advance;

   // ---------------------------------------------------------------- operand stage
   if (STAGES > 1) begin : g_opnd
      logic             v_q;
      logic [XLEN-1:0]  a_q;
      logic [XLEN-1:0]  b_q;
      logic [1:0]       op_q;
      logic [1:0]       prec_q;
      logic [TAG_W-1:0] tag_q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            v_q    <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            prec_q <= '0;
            tag_q  <= '0;
         end else if (advance) begin
            v_q <= bus.in_valid;
            if (bus.in_valid) begin
               a_q    <= bus.operand_a;
               b_q    <= bus.operand_b;
               op_q   <= bus.opcode;
               prec_q <= bus.precision;
               tag_q  <= bus.tag_in;
            end
         end
      end

      assign src_valid = v_q;
      assign src_a     = a_q;
      assign src_b     = b_q;
      assign src_op    = op_q;
      assign src_prec  = prec_q;
      assign src_tag   = tag_q;
   end else begin : g_direct
      assign src_valid = bus.in_valid;
      assign src_a     = bus.operand_a;
      assign src_b     = bus.operand_b;
      assign src_op    = bus.opcode;
      assign src_prec  = bus.precision;
      assign src_tag   = bus.tag_in;
   end

   // ---------------------------------------------------------------- lane multiply
   logic                 sign_a;
   logic                 sign_b;
   logic                 take_hi;
   logic [1:0]           prec_eff;
   logic [3:0][XLEN-1:0] lane_res;
   logic [XLEN-1:0]      mul_res;

   always_comb begin
      sign_a   = (src_op == OP_MULH) || (src_op == OP_MULHSU);
      sign_b   = (src_op == OP_MULH);
      take_hi  = (src_op != OP_MUL);
      prec_eff = src_prec;
      if ((XLEN < 64) && (src_prec == 2'b11)) begin
         prec_eff = 2'b10;
      end
      mul_res = lane_res[prec_eff];
   end

   // Every width is computed in parallel and selected afterwards. Each lane
   // operand is extended to 2w bits; the true product always fits in 2w bits
   // for any signedness mix, so the modulo-2^2w product is exact.
   for (genvar p = 0; p < 4; p++) begin : g_prec
      localparam int unsigned W = 8 << p;
      if (W <= XLEN) begin : g_on
         for (genvar l = 0; l < XLEN / W; l++) begin : g_lane
            logic [W-1:0]   la;
            logic [W-1:0]   lb;
            logic [2*W-1:0] xa;
            logic [2*W-1:0] xb;
            logic [2*W-1:0] prod;

            assign la   = src_a[l*W +: W];
            assign lb   = src_b[l*W +: W];
            assign xa   = {{W{sign_a & la[W-1]}}, la};
            assign xb   = {{W{sign_b & lb[W-1]}}, lb};
            assign prod = xa * xb;
            assign lane_res[p][l*W +: W] = take_hi ? prod[2*W-1:W] : prod[W-1:0];
         end
      end else begin : g_off
         assign lane_res[p] = '0;
      end
   end

   // ---------------------------------------------------------------- result stages
   logic             rv [RDEPTH];
   logic [XLEN-1:0]  rd [RDEPTH];
   logic [TAG_W-1:0] rt [RDEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < RDEPTH; i++) begin
            rv[i] <= 1'b0;
            rd[i] <= '0;
            rt[i] <= '0;
         end
      end else if (advance) begin
         rv[0] <= src_valid;
         if (src_valid) begin
            rd[0] <= mul_res;
            rt[0] <= src_tag;
         end
         for (int unsigned i = 1; i < RDEPTH; i++) begin
            rv[i] <= rv[i-1];
            if (rv[i-1]) begin
               rd[i] <= rd[i-1];
               rt[i] <= rt[i-1];
            end
         end
      end
   end

   assign bus.out_valid = rv[RDEPTH-1];
   assign bus.mul_out   = rd[RDEPTH-1];
   assign bus.tag_out   = rt[RDEPTH-1];

endmodule
